layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Inter-layer scheduler between one neuron layer and the next layer's serial input.
- Collects per-neuron results into a collect buffer; each neuron's valid pulse may arrive on a different cycle.
- On a complete frame, transfers the results to a stream buffer and sequences them one word per handshake into the downstream layer.
- Double-buffered so the next frame can be collected while the current frame streams.
- Reports overrun, busy and a completed-frame count for the control/status path.

Parameters:
DATA_WIDTH, 16, width of one neuron output word
NUM_NEURONS, 30, neurons in the producing layer (2..64)
IDX_WIDTH, 5, stream index width, must be >= clog2(NUM_NEURONS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
soft_rst  in  1  synchronous clear, same effect as rst
in_data  in  NUM_NEURONS*DATA_WIDTH  neuron outputs, neuron k at bits [k*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  NUM_NEURONS  per-neuron single-cycle valid pulses
out_data  out  DATA_WIDTH  streamed word
out_valid  out  1  stream valid
out_ready  in  1  downstream ready
out_last  out  1  high with the final word of a frame
busy  out  1  high in STREAM state or when any collected bit is set
overrun  out  1  sticky error flag
frame_count  out  16  frames fully streamed, wraps at 16'hFFFF to 0

Behaviour:
- Reset values (rst, or soft_rst at the next edge): out_valid=0, out_data=0, out_last=0, busy=0, overrun=0, frame_count=0. Reset also clears both buffers, the collected bits, the index and the state. rst acts immediately and may occur mid-frame or mid-stream; any partial frame is discarded.
- Collect stage:
  - On in_valid[k]=1 with collected[k]=0: latch in_data slice k into collect buffer k; set collected[k].
  - On in_valid[k]=1 with collected[k]=1 (duplicate pulse) and no transfer in that cycle: ignore the data and set overrun. overrun stays set until rst or soft_rst.
  - frame_ready = AND of all collected bits (combinational).
- Transfer rule: transfer happens when frame_ready=1 AND (state==IDLE OR the final-word handshake occurs this cycle). On transfer:
  - Copy the collect buffer to the stream buffer.
  - Clear all collected bits.
  - Set idx=0 and state=STREAM.
  - Any in_valid pulse in the transfer cycle is accepted as the first word of the next frame, not an overrun.
- FSM:
  - IDLE: out_valid=0. Goes to STREAM on transfer.
  - STREAM: out_valid=1 and out_data=stream_buf[idx]. On handshake (out_valid & out_ready), idx increments.
  - Final handshake at idx==NUM_NEURONS-1: frame_count increments. Next state is STREAM with idx=0 if a transfer occurs that cycle (back-to-back, no bubble); otherwise IDLE.
- out_last = out_valid & (idx==NUM_NEURONS-1).
- Stall: while out_ready=0, out_data, out_last and idx hold stable. out_valid is never withdrawn before the handshake.
- Latency: the final missing pulse is sampled at edge N, transfer occurs at edge N+1, and out_valid=1 is visible after edge N+1. The first word appears 2 cycles after that pulse.
- out_data is 0 whenever out_valid=0.
- Throughput: 1 word per clock with out_ready held high.

Test Plan:
- All 30 in_valid asserted in one cycle, neuron k data=3k, out_ready=1 -> out_valid rises 2 cycles later; 30 consecutive words 0,3,...,87; out_last only on word 29; frame_count=1; busy falls after the last beat.
- Staggered pulses, neuron k at cycle 10+k -> no output before cycle 39; first word 2 cycles after neuron 29's pulse; order by neuron index, not arrival order.
- out_ready alternating 1,0 during streaming -> out_data and out_last stable while stalled; 30 beats over 60 cycles; no word lost or duplicated.
- Second full frame (data 100+k) collected during streaming of the first -> word 0 of the second frame on the cycle after the first frame's last handshake, no idle cycle; frame_count=2; overrun=0.
- Duplicate in_valid[5] with data 999 before the frame completes -> overrun=1; neuron 5 streams its original value; overrun stays 1 until soft_rst, which clears it and frame_count to 0.
- rst asserted at beat 10 of a frame -> out_valid, out_last and busy go 0 immediately (asynchronously); after release, a new frame streams from index 0 with correct data.

Source files
------------

// File: rtl/layer_sequencer.sv
// Inter-layer scheduler: collects per-neuron results into a collect buffer, then
// streams a completed frame one word per handshake while the next frame is collected.
module layer_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_NEURONS = 30,
  parameter int IDX_WIDTH   = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              soft_rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              overrun,
  output logic [15:0]                       frame_count
);

  // state    | meaning
  // S_IDLE   | nothing streaming, waiting for a complete collected frame
  // S_STREAM | presenting stream_buf[idx] to the downstream layer
  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [NUM_NEURONS-1:0] collected_q, collected_d;
  logic                   overrun_q, overrun_d;
  logic [15:0]            frame_count_q, frame_count_d;

  logic [DATA_WIDTH-1:0]  coll_buf_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]  strm_buf_q [NUM_NEURONS];

  logic                   frame_ready;
  logic                   at_last;
  logic                   handshake;
  logic                   last_hs;
  logic                   transfer;
  logic [NUM_NEURONS-1:0] accept;

  always_comb begin
    frame_ready = &collected_q;
    out_valid   = (state_q == S_STREAM);
    at_last     = (idx_q == LAST_IDX);
    handshake   = out_valid & out_ready;
    last_hs     = handshake & at_last;
    transfer    = frame_ready & ((state_q == S_IDLE) | last_hs);
    // In a transfer cycle the collected bits are being cleared, so every pulse
    // belongs to the next frame.
    accept      = in_valid & (~collected_q | {NUM_NEURONS{transfer}});
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    collected_d   = collected_q | in_valid;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;

    if (!transfer && (|(in_valid & collected_q))) begin
      overrun_d = 1'b1;
    end

    if (last_hs) begin
      frame_count_d = frame_count_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end
      end
      S_STREAM: begin
        if (handshake) begin
          if (at_last) begin
            idx_d   = '0;
            state_d = transfer ? S_STREAM : S_IDLE;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    if (transfer) begin
      collected_d = in_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      collected_q   <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= 16'd0;
    end else if (soft_rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      collected_q   <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      collected_q   <= collected_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Stream buffer copies the registered collect buffer, so words latched during
  // the transfer cycle land in the next frame only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        coll_buf_q[k] <= '0;
        strm_buf_q[k] <= '0;
      end
    end else if (soft_rst) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        coll_buf_q[k] <= '0;
        strm_buf_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        if (accept[k]) begin
          coll_buf_q[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
        if (transfer) begin
          strm_buf_q[k] <= coll_buf_q[k];
        end
      end
    end
  end

  always_comb begin
    out_data    = out_valid ? strm_buf_q[idx_q] : '0;
    out_last    = out_valid & at_last;
    busy        = out_valid | (|collected_q);
    overrun     = overrun_q;
    frame_count = frame_count_q;
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: stimulus pushes expected words into a
// scoreboard queue, a negedge monitor pops and compares on every handshake.
module tb_layer_sequencer;

  localparam int DW = 16;
  localparam int NN = 30;

  logic             clk = 1'b0;
  logic             rst;
  logic             soft_rst;
  logic [NN*DW-1:0] in_data;
  logic [NN-1:0]    in_valid;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             overrun;
  logic [15:0]      frame_count;

  layer_sequencer #(.DATA_WIDTH(DW), .NUM_NEURONS(NN), .IDX_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  logic [16:0] sbq[$];
  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive word k = base + step*k on every slice and queue the expected stream.
  task automatic set_frame(input int base, input int step);
    for (int k = 0; k < NN; k++) begin
      in_data[k*DW +: DW] = DW'(base + step*k);
      sbq.push_back({(k == NN-1), DW'(base + step*k)});
    end
  endtask

  task automatic pulse_all(input int base, input int step);
    set_frame(base, step);
    in_valid = '1;
    tick();
    in_valid = '0;
  endtask

  task automatic run_stream(input string name, input int exp_cycles);
    int cnt;
    cnt = 0;
    out_ready = 1'b1;
    while (out_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    check(name, cnt, exp_cycles);
  endtask

  // Monitor
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [16:0]   e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL sb_underflow: got word %0d expected none", out_data);
        end else begin
          e = sbq.pop_front();
          check("word_data", out_data, e[15:0]);
          check("word_last", out_last, e[16]);
        end
      end else if (!out_valid) begin
        check("idle_outputs", {out_last, out_data}, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic r;
    rst = 1'b1; soft_rst = 1'b0; in_data = '0; in_valid = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fc", frame_count, 0);

    // 1: all neurons at once, data 3k
    pulse_all(0, 3);
    check("t1_lat_edgeN_valid", out_valid, 0);
    check("t1_lat_edgeN_busy", busy, 1);
    tick();
    check("t1_lat_edgeN1_valid", out_valid, 1);
    run_stream("t1_beats", 30);
    check("t1_busy_after", busy, 0);
    check("t1_fc", frame_count, 1);

    // 2: staggered arrival in reverse neuron order
    for (int i = 0; i < NN; i++) begin
      in_valid = '0;
      in_valid[NN-1-i] = 1'b1;
      in_data[(NN-1-i)*DW +: DW] = DW'(40 + 5*(NN-1-i));
      tick();
      check("t2_no_early_out", out_valid, 0);
    end
    in_valid = '0;
    for (int k = 0; k < NN; k++) sbq.push_back({(k == NN-1), DW'(40 + 5*k)});
    tick();
    check("t2_first_word_valid", out_valid, 1);
    run_stream("t2_beats", 30);
    check("t2_fc", frame_count, 2);

    // 3: ready alternating during the stream
    pulse_all(1000, 1);
    tick();
    cnt = 0; r = 1'b0;
    while (out_valid && cnt < 200) begin
      out_ready = r;
      r = ~r;
      tick();
      cnt++;
    end
    out_ready = 1'b1;
    check("t3_cycles", cnt, 60);
    check("t3_fc", frame_count, 3);

    // 4: second frame collected while the first streams, back to back
    pulse_all(0, 7);
    tick();
    cnt = 0;
    while (out_valid && cnt < 200) begin
      if (cnt == 3) begin
        set_frame(100, 1);
        in_valid = '1;
      end
      tick();
      in_valid = '0;
      cnt++;
    end
    check("t4_no_bubble_cycles", cnt, 60);
    check("t4_fc", frame_count, 5);
    check("t4_overrun", overrun, 0);

    // 5: duplicate pulse on neuron 5
    for (int k = 0; k < NN-1; k++) in_data[k*DW +: DW] = DW'(11*k + 3);
    in_valid = '1;
    in_valid[NN-1] = 1'b0;
    tick();
    in_valid = '0;
    check("t5_overrun_pre", overrun, 0);
    in_data[5*DW +: DW] = DW'(999);
    in_valid[5] = 1'b1;
    tick();
    in_valid = '0;
    check("t5_overrun_set", overrun, 1);
    check("t5_no_out", out_valid, 0);
    in_data[(NN-1)*DW +: DW] = DW'(11*(NN-1) + 3);
    in_valid[NN-1] = 1'b1;
    for (int k = 0; k < NN; k++) sbq.push_back({(k == NN-1), DW'(11*k + 3)});
    tick();
    in_valid = '0;
    tick();
    run_stream("t5_beats", 30);
    check("t5_overrun_sticky", overrun, 1);
    check("t5_fc", frame_count, 6);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("t5_soft_overrun", overrun, 0);
    check("t5_soft_fc", frame_count, 0);
    check("t5_soft_busy", busy, 0);

    // 6: async reset at beat 10
    pulse_all(1, 2);
    tick();
    repeat (10) tick();
    check("t6_streaming", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_last", out_last, 0);
    check("t6_rst_busy", busy, 0);
    sbq.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
    check("t6_post_fc", frame_count, 0);
    check("t6_post_busy", busy, 0);
    pulse_all(500, 1);
    tick();
    run_stream("t6_beats", 30);
    check("t6_fc", frame_count, 1);

    tick();
    check("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
